// File: rtl/hack_pkg.sv
// Shared FSM state type and instruction field positions for the Hack CPU sequencer.
package hack_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MRD,
        ST_ALU,
        ST_MWR,
        ST_HALT
    } state_t;

    localparam int IS_C    = 15;
    localparam int A_BIT   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JMP_LT  = 2;
    localparam int JMP_EQ  = 1;
    localparam int JMP_GT  = 0;

endpackage

// File: rtl/hack_jmp_cond.sv
// Jump resolution: maps the 3-bit jump field and ALU flags to a taken decision.
module hack_jmp_cond
    import hack_pkg::*;
(
    input  logic [2:0] i_j,
    input  logic       i_zr,
    input  logic       i_ng,
    output logic       o_taken
);

    assign o_taken = (i_j[JMP_LT] & i_ng)
                   | (i_j[JMP_EQ] & i_zr)
                   | (i_j[JMP_GT] & ~i_ng & ~i_zr);

endmodule

// File: rtl/hack_cpu_seq.sv
// Multi-cycle Hack CPU sequencer and A/D register file driving an external ALU.
// Optional halt detection on self-jumps is enabled with HACK_HALT_DET_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_FETCH  | instr_req high, wait for instr_ack, latch ir
// ST_DECODE | A-instr executes here; C-instr chooses M read or ALU
// ST_MRD    | mem_re high at A, wait for mem_ack, latch mdr
// ST_ALU    | one-cycle writeback of A/D, jump resolution, optional M write
// ST_MWR    | mem_we high with latched address/data, wait for mem_ack
// ST_HALT   | self-jump detected, no requests, registers frozen
module hack_cpu_seq
    import hack_pkg::*;
#(
    parameter int ADDR_W   = 15,
    parameter int RESET_PC = 0
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic              o_instr_req,
    output logic [ADDR_W-1:0] o_instr_addr,
    input  logic [15:0]       i_instr_data,
    input  logic              i_instr_ack,
    output logic              o_mem_re,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    input  logic [15:0]       i_mem_rdata,
    input  logic              i_mem_ack,
    output logic [15:0]       o_alu_x,
    output logic [15:0]       o_alu_y,
    output logic [5:0]        o_alu_ctrl,
    input  logic [15:0]       i_alu_o,
    input  logic              i_alu_zr,
    input  logic              i_alu_ng,
    output logic [15:0]       o_a_reg,
    output logic [15:0]       o_d_reg,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_a;
    logic [15:0]       r_d;
    logic [15:0]       r_ir;
    logic [15:0]       r_mdr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_instr_req;
    logic              r_mem_re;
    logic              r_mem_we;

    logic              w_taken;
    logic              w_halt_now;
    logic              w_halted;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_a_addr;

    assign w_pc_inc = r_pc + PC_ONE;
    assign w_a_addr = r_a[ADDR_W-1:0];

    hack_jmp_cond u_jmp_cond (
        .i_j     (r_ir[JMP_LT:JMP_GT]),
        .i_zr    (i_alu_zr),
        .i_ng    (i_alu_ng),
        .o_taken (w_taken)
    );

`ifdef HACK_HALT_DET_EN
    logic r_halted;

    // A taken jump whose target is the instruction itself can never leave the loop.
    assign w_halt_now = w_taken && (w_a_addr == r_pc);
    assign w_halted   = r_halted;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halted <= 1'b0;
        end else if (r_state == ST_ALU && w_halt_now) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_halt_now = 1'b0;
    assign w_halted   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_FETCH;
            r_pc        <= PC_RST;
            r_a         <= '0;
            r_d         <= '0;
            r_ir        <= '0;
            r_mdr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_instr_req <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    // Requests are registered, so the first fetch after reset spends one cycle raising req.
                    if (!r_instr_req) begin
                        r_instr_req <= 1'b1;
                    end else if (i_instr_ack) begin
                        r_ir        <= i_instr_data;
                        r_instr_req <= 1'b0;
                        r_state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!r_ir[IS_C]) begin
                        r_a         <= r_ir;
                        r_pc        <= w_pc_inc;
                        r_instr_req <= 1'b1;
                        r_state     <= ST_FETCH;
                    end else if (r_ir[A_BIT]) begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_a_addr;
                        r_state    <= ST_MRD;
                    end else begin
                        r_state <= ST_ALU;
                    end
                end
                ST_MRD: begin
                    if (i_mem_ack) begin
                        r_mdr    <= i_mem_rdata;
                        r_mem_re <= 1'b0;
                        r_state  <= ST_ALU;
                    end
                end
                ST_ALU: begin
                    if (r_ir[DEST_A]) r_a <= i_alu_o;
                    if (r_ir[DEST_D]) r_d <= i_alu_o;
                    r_pc <= w_taken ? w_a_addr : w_pc_inc;
                    // The M address and jump target both use A as it was before this writeback.
                    if (r_ir[DEST_M]) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= w_a_addr;
                        r_mem_wdata <= i_alu_o;
                        r_state     <= ST_MWR;
                    end else if (w_halt_now) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_instr_req <= 1'b1;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_MWR: begin
                    if (i_mem_ack) begin
                        r_mem_we <= 1'b0;
                        if (w_halted) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_instr_req <= 1'b1;
                            r_state     <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    assign o_instr_req  = r_instr_req;
    assign o_instr_addr = r_pc;
    assign o_mem_re     = r_mem_re;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_alu_x      = r_d;
    assign o_alu_y      = r_ir[A_BIT] ? r_mdr : r_a;
    assign o_alu_ctrl   = r_ir[CTRL_HI:CTRL_LO];
    assign o_a_reg      = r_a;
    assign o_d_reg      = r_d;
    assign o_pc         = r_pc;
    assign o_halted     = w_halted;

endmodule

// File: tb/tb_hack_cpu_seq.sv
// Bench for hack_cpu_seq: memory/ALU responder plus an instruction-level Hack ISA reference model.
module tb_hack_cpu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_ack = 1'b0;
    logic [15:0] instr_data = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] alu_o;
    logic        alu_zr, alu_ng;

    logic        instr_req, mem_re, mem_we, halted;
    logic [14:0] instr_addr, mem_addr, pc;
    logic [15:0] mem_wdata, alu_x, alu_y, a_reg, d_reg;
    logic [5:0]  alu_ctrl;

    hack_cpu_seq #(.ADDR_W(15), .RESET_PC(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .o_instr_req(instr_req), .o_instr_addr(instr_addr),
        .i_instr_data(instr_data), .i_instr_ack(instr_ack),
        .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
        .o_alu_x(alu_x), .o_alu_y(alu_y), .o_alu_ctrl(alu_ctrl),
        .i_alu_o(alu_o), .i_alu_zr(alu_zr), .i_alu_ng(alu_ng),
        .o_a_reg(a_reg), .o_d_reg(d_reg), .o_pc(pc), .o_halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        logic [15:0] a, b, r;
        a = c[5] ? 16'h0000 : x;
        if (c[4]) a = ~a;
        b = c[3] ? 16'h0000 : y;
        if (c[2]) b = ~b;
        r = c[1] ? (a + b) : (a & b);
        if (c[0]) r = ~r;
        return r;
    endfunction

    // External ALU seen by the DUT.
    assign alu_o  = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr = (alu_o == 16'h0000);
    assign alu_ng = alu_o[15];

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] imem[int];
    logic [15:0] dmem[int];
    logic [15:0] mmem[int];

    function automatic logic [15:0] init_word(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15] && $urandom_range(3) != 0) w[2:0] = 3'b000;
        return w;
    endfunction

    function automatic logic [15:0] imem_get(input int a);
        if (!imem.exists(a)) imem[a] = rand_instr();
        return imem[a];
    endfunction

    function automatic logic [15:0] dmem_get(input int a);
        return dmem.exists(a) ? dmem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] mmem_get(input int a);
        return mmem.exists(a) ? mmem[a] : init_word(a);
    endfunction

    // ISA-level reference state
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;
    logic [14:0] exp_rd[$];
    logic [30:0] exp_wr[$];

    task automatic model_exec(input logic [15:0] w);
        logic [15:0] y, r, old_a;
        logic zr, ng, jmp;
        if (!w[15]) begin
            m_a  = w;
            m_pc = m_pc + 15'd1;
        end else begin
            old_a = m_a;
            if (w[12]) begin
                y = mmem_get(int'(old_a[14:0]));
                exp_rd.push_back(old_a[14:0]);
            end else begin
                y = old_a;
            end
            r   = hack_alu(m_d, y, w[11:6]);
            zr  = (r == 16'h0000);
            ng  = r[15];
            jmp = (w[2] && ng) || (w[1] && zr) || (w[0] && !ng && !zr);
            if (w[3]) begin
                exp_wr.push_back({old_a[14:0], r});
                mmem[int'(old_a[14:0])] = r;
            end
            if (w[5]) m_a = r;
            if (w[4]) m_d = r;
            m_pc = jmp ? old_a[14:0] : m_pc + 15'd1;
        end
    endtask

    bit          model_en = 1'b0;
    int          dly_i = 0, dly_m = 0;
    int          cyc = 0, last_fetch_cyc = 0, n_fetch = 0;
    int          re_cyc = 0, we_cyc = 0;
    logic [14:0] last_wa;
    logic [15:0] last_wd;
    logic [14:0] f_pc[$];
    logic [15:0] f_a[$];
    logic [15:0] f_d[$];
    logic [5:0]  f_ctrl[$];
    int          f_gap[$];

    initial begin : responder
        int wi, wm;
        logic [15:0] w;
        logic [14:0] ea;
        logic [30:0] ew;
        wi = 0;
        wm = 0;
        forever begin
            @(negedge clk);
            cyc++;
            instr_ack = 1'b0;
            mem_ack   = 1'b0;
            if (!rst_n || !model_en) begin
                wi = 0;
                wm = 0;
            end else begin
                check("req_exclusive", 32'((32'(instr_req) + 32'(mem_re) + 32'(mem_we)) <= 1), 32'd1);
                if (mem_re) re_cyc++;
                if (mem_we) we_cyc++;
                if (instr_req) begin
                    if (wi + 1 >= dly_i) begin
                        check("fetch_addr", 32'(instr_addr), 32'(m_pc));
                        check("pc", 32'(pc), 32'(m_pc));
                        check("a_reg", 32'(a_reg), 32'(m_a));
                        check("d_reg", 32'(d_reg), 32'(m_d));
                        w = imem_get(int'(instr_addr));
                        instr_data = w;
                        instr_ack  = 1'b1;
                        wi = 0;
                        f_pc.push_back(instr_addr);
                        f_a.push_back(a_reg);
                        f_d.push_back(d_reg);
                        f_ctrl.push_back(alu_ctrl);
                        f_gap.push_back(cyc - last_fetch_cyc);
                        last_fetch_cyc = cyc;
                        model_exec(w);
                        n_fetch++;
                    end else begin
                        wi++;
                    end
                end
                if (mem_re || mem_we) begin
                    if (wm + 1 >= dly_m) begin
                        if (mem_re) begin
                            ea = (exp_rd.size() > 0) ? exp_rd.pop_front() : 15'bx;
                            check("rd_addr", 32'(mem_addr), 32'(ea));
                            mem_rdata = dmem_get(int'(mem_addr));
                        end else begin
                            ew = (exp_wr.size() > 0) ? exp_wr.pop_front() : 31'bx;
                            check("wr_addr", 32'(mem_addr), 32'(ew[30:16]));
                            check("wr_data", 32'(mem_wdata), 32'(ew[15:0]));
                            dmem[int'(mem_addr)] = mem_wdata;
                            last_wa = mem_addr;
                            last_wd = mem_wdata;
                        end
                        mem_ack = 1'b1;
                        wm = 0;
                    end else begin
                        wm++;
                    end
                end
            end
        end
    end

    task automatic do_reset(input int di, input int dm);
        rst_n    = 1'b0;
        model_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_instr_req", 32'(instr_req), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_a", 32'(a_reg), 32'd0);
        check("rst_d", 32'(d_reg), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        m_pc = '0;
        m_a  = '0;
        m_d  = '0;
        exp_rd.delete();
        exp_wr.delete();
        dmem.delete();
        mmem.delete();
        f_pc.delete();
        f_a.delete();
        f_d.delete();
        f_ctrl.delete();
        f_gap.delete();
        n_fetch = 0;
        re_cyc  = 0;
        we_cyc  = 0;
        last_fetch_cyc = cyc;
        dly_i = di;
        dly_m = dm;
        rst_n    = 1'b1;
        model_en = 1'b1;
    endtask

    task automatic wait_fetch(input int n, input string tag);
        int b;
        b = 0;
        while (n_fetch < n && b < 5000) begin
            @(negedge clk);
            b++;
        end
        check({tag, "_timeout"}, 32'(n_fetch >= n), 32'd1);
    endtask

    task automatic preset_data(input int a, input logic [15:0] v);
        dmem[a] = v;
        mmem[a] = v;
    endtask

    initial begin : main
        int b;
        // A-instruction, single-cycle fetch ack
        imem.delete();
        imem[0] = 16'h0005;
        imem[1] = 16'h0005;
        do_reset(0, 0);
        wait_fetch(3, "t1");
        check("t1_a", 32'(f_a[1]), 32'd5);
        check("t1_pc", 32'(f_pc[1]), 32'd1);
        check("t1_latency", 32'(f_gap[1]), 32'd2);
        check("t1_no_mem", 32'(re_cyc + we_cyc), 32'd0);

        // @7; D=A; D=D+1
        imem.delete();
        imem[0] = 16'h0007;
        imem[1] = 16'hEC10;
        imem[2] = 16'hE7D0;
        imem[3] = 16'h0000;
        do_reset(0, 0);
        wait_fetch(4, "t2");
        check("t2_d", 32'(f_d[3]), 32'd8);
        check("t2_ctrl_dplus1", 32'(f_ctrl[3]), 32'h1F);
        check("t2_latency", 32'(f_gap[3]), 32'd3);

        // @3; M=M+1 with three-cycle data ack
        imem.delete();
        imem[0] = 16'h0003;
        imem[1] = 16'hFDC8;
        imem[2] = 16'h0000;
        do_reset(0, 3);
        preset_data(3, 16'h1234);
        wait_fetch(3, "t3");
        check("t3_re_cycles", 32'(re_cyc), 32'd3);
        check("t3_we_cycles", 32'(we_cyc), 32'd3);
        check("t3_waddr", 32'(last_wa), 32'd3);
        check("t3_wdata", 32'(last_wd), 32'h1235);
        check("t3_latency", 32'(f_gap[2]), 32'd9);

        // @10; AM=M-1: write lands at the old A
        imem.delete();
        imem[0] = 16'h000A;
        imem[1] = 16'hFCA8;
        imem[2] = 16'h0000;
        do_reset(1, 1);
        preset_data(10, 16'h0050);
        wait_fetch(3, "t4");
        check("t4_waddr", 32'(last_wa), 32'd10);
        check("t4_wdata", 32'(last_wd), 32'h004F);
        check("t4_a", 32'(f_a[2]), 32'h004F);

        // JLT taken, JGT not taken, pc wrap
        imem.delete();
        imem[0]     = 16'h0014;
        imem[1]     = 16'hEE90;
        imem[2]     = 16'hE304;
        imem[20]    = 16'hEA90;
        imem[21]    = 16'hE301;
        imem[22]    = 16'h7FFF;
        imem[23]    = 16'hEA87;
        imem[32767] = 16'h0001;
        do_reset(2, 2);
        wait_fetch(9, "t5");
        check("t5_jlt_pc", 32'(f_pc[3]), 32'd20);
        check("t5_jgt_pc", 32'(f_pc[5]), 32'd22);
        check("t5_jgt_d", 32'(f_d[5]), 32'd0);
        check("t5_jmp_pc", 32'(f_pc[7]), 32'h7FFF);
        check("t5_wrap_pc", 32'(f_pc[8]), 32'd0);

        // Reset while a write is pending
        imem.delete();
        imem[0] = 16'h0005;
        imem[1] = 16'hEFC8;
        imem[2] = 16'h0000;
        do_reset(0, 50);
        b = 0;
        while (!mem_we && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("t6_we_seen", 32'(mem_we), 32'd1);
        #2;
        rst_n    = 1'b0;
        model_en = 1'b0;
        #1;
        check("t6_we_drop", 32'(mem_we), 32'd0);
        check("t6_pc_reset", 32'(pc), 32'd0);

`ifdef HACK_HALT_DET_EN
        // @1 at address 0, then 0;JMP at address 1 jumps to itself
        imem.delete();
        imem[0] = 16'h0001;
        imem[1] = 16'hEA87;
        do_reset(0, 0);
        b = 0;
        while (!halted && b < 200) begin
            @(negedge clk);
            b++;
        end
        check("t7_halted", 32'(halted), 32'd1);
        b = 0;
        repeat (10) begin
            @(negedge clk);
            if (instr_req || mem_re || mem_we) b++;
        end
        check("t7_no_requests", 32'(b), 32'd0);
        check("t7_pc", 32'(pc), 32'd1);
`else
        // Random programs against the ISA model
        for (int r = 0; r < 3; r++) begin
            imem.delete();
            do_reset(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            wait_fetch(300, "rand");
            check("rand_halted", 32'(halted), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
